// File: rtl/vga_pattern_if.sv
// Pixel-side bundle of the VGA pattern generator: timing inputs in, registered colour and syncs out.
// The master modport is the timing/board side, the slave modport is the pattern generator.
interface vga_pattern_if #(
    parameter int COLOR_BITS = 2,
    parameter int COORD_W    = 10
);
    logic                  vga_pixel_active;
    logic [COORD_W-1:0]    vga_x;
    logic [COORD_W-1:0]    vga_y;
    logic                  vga_hsync_in;
    logic                  vga_vsync_in;
    logic [COLOR_BITS-1:0] vga_r;
    logic [COLOR_BITS-1:0] vga_g;
    logic [COLOR_BITS-1:0] vga_b;
    logic                  vga_hsync;
    logic                  vga_vsync;

    modport master (
        output vga_pixel_active, vga_x, vga_y, vga_hsync_in, vga_vsync_in,
        input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync
    );

    modport slave (
        input  vga_pixel_active, vga_x, vga_y, vga_hsync_in, vga_vsync_in,
        output vga_r, vga_g, vga_b, vga_hsync, vga_vsync
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator with frame-aligned mode switching and a 1-cycle colour/sync pipeline.
// Define VGA_PATTERN_ANIM_EN to build the frame counter and the animated stripe mode (mode 4).
//
// state       | meaning
// ST_WAIT_FS  | after reset: blank output until the first frame start
// ST_RUN      | rendering the active mode
module vga_pattern_gen #(
    parameter int       COLOR_BITS   = 2,
    parameter int       COORD_W      = 10,
    parameter int       H_ACTIVE     = 640,
    parameter int       V_ACTIVE     = 480,
    parameter int       CHECK_SHIFT  = 5,
    parameter int       STRIPE_SHIFT = 4,
    parameter int       FRAME_W      = 8,
    parameter logic     SYNC_IDLE    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_pattern_if.slave       bus,
    input  logic [2:0]         mode_sel,
    input  logic               mode_load,
    output logic [2:0]         active_mode,
    output logic [FRAME_W-1:0] frame_cnt
);
    localparam logic [0:0]            ST_WAIT_FS = 1'b0;
    localparam logic [0:0]            ST_RUN     = 1'b1;
    localparam logic [COLOR_BITS-1:0] MAX        = '1;
    localparam int                    BAR_W      = H_ACTIVE / 8;

    if (CHECK_SHIFT >= COORD_W || STRIPE_SHIFT >= COORD_W || COORD_W < COLOR_BITS + 3) begin : g_param_check
        $error("vga_pattern_gen: pattern shift or tile bits exceed COORD_W");
    end

    logic [0:0]            r_state;
    logic [2:0]            r_pending_mode;
    logic [2:0]            r_active_mode;
    logic [COLOR_BITS-1:0] r_r, r_g, r_b;
    logic                  r_hsync, r_vsync;

    logic                  w_fs;
    logic [2:0]            w_mode;
    logic                  w_render;
    logic [COLOR_BITS-1:0] w_x_tile, w_y_tile, w_grad;
    logic [COORD_W-1:0]    w_bar_idx;
    logic [2:0]            w_bar_clamped;
    logic [2:0]            w_bar_code;
    logic                  w_checker;
    logic [COLOR_BITS-1:0] w_r, w_g, w_b;

    assign w_fs     = bus.vga_pixel_active && (bus.vga_x == '0) && (bus.vga_y == '0);
    // The frame-start pixel is already drawn in the newly applied mode.
    assign w_mode   = w_fs ? r_pending_mode : r_active_mode;
    assign w_render = bus.vga_pixel_active && (w_fs || (r_state == ST_RUN));

    assign w_x_tile      = bus.vga_x[3 +: COLOR_BITS];
    assign w_y_tile      = bus.vga_y[3 +: COLOR_BITS];
    assign w_grad        = bus.vga_x[COORD_W-1 -: COLOR_BITS];
    assign w_bar_idx     = bus.vga_x / COORD_W'(BAR_W);
    assign w_bar_clamped = (w_bar_idx > COORD_W'(7)) ? 3'd7 : w_bar_idx[2:0];
    assign w_bar_code    = 3'd7 - w_bar_clamped;
    assign w_checker     = bus.vga_x[CHECK_SHIFT] ^ bus.vga_y[CHECK_SHIFT];

`ifdef VGA_PATTERN_ANIM_EN
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [COORD_W-1:0] w_stripe_sum;

    assign w_stripe_sum = bus.vga_x + bus.vga_y + COORD_W'(r_frame_cnt);
    assign frame_cnt    = r_frame_cnt;

    // Counts on the edge that registers the frame-start pixel, so that pixel sees the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_fs) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end
`else
    assign frame_cnt = '0;
`endif

    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_render) begin
            case (w_mode)
                3'd0: begin
                    if (bus.vga_x == '0) begin
                        w_r = MAX;
                    end else if (bus.vga_x == COORD_W'(H_ACTIVE - 1)) begin
                        w_g = MAX;
                    end else if (bus.vga_y == '0) begin
                        w_b = MAX;
                    end else if (bus.vga_y == COORD_W'(V_ACTIVE - 1)) begin
                        w_r = MAX;
                        w_g = MAX;
                        w_b = MAX;
                    end else begin
                        w_r = w_x_tile;
                        w_g = w_y_tile;
                        w_b = ~(w_x_tile ^ w_y_tile);
                    end
                end
                3'd1: begin
                    w_r = {COLOR_BITS{w_bar_code[2]}};
                    w_g = {COLOR_BITS{w_bar_code[1]}};
                    w_b = {COLOR_BITS{w_bar_code[0]}};
                end
                3'd2: begin
                    w_r = {COLOR_BITS{w_checker}};
                    w_g = {COLOR_BITS{w_checker}};
                    w_b = {COLOR_BITS{w_checker}};
                end
                3'd3: begin
                    w_r = w_grad;
                    w_g = w_grad;
                    w_b = w_grad;
                end
`ifdef VGA_PATTERN_ANIM_EN
                3'd4: begin
                    w_r = {COLOR_BITS{w_stripe_sum[STRIPE_SHIFT]}};
                    w_g = {COLOR_BITS{w_stripe_sum[STRIPE_SHIFT]}};
                    w_b = {COLOR_BITS{w_stripe_sum[STRIPE_SHIFT]}};
                end
`endif
                default: begin
                    w_r = '0;
                    w_g = '0;
                    w_b = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_WAIT_FS;
            r_pending_mode <= 3'd0;
            r_active_mode  <= 3'd0;
        end else begin
            if (w_fs) begin
                r_state       <= ST_RUN;
                r_active_mode <= r_pending_mode;
            end
            if (mode_load) begin
                r_pending_mode <= mode_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
            r_hsync <= SYNC_IDLE;
            r_vsync <= SYNC_IDLE;
        end else begin
            r_r     <= w_r;
            r_g     <= w_g;
            r_b     <= w_b;
            r_hsync <= bus.vga_hsync_in;
            r_vsync <= bus.vga_vsync_in;
        end
    end

    assign bus.vga_r     = r_r;
    assign bus.vga_g     = r_g;
    assign bus.vga_b     = r_b;
    assign bus.vga_hsync = r_hsync;
    assign bus.vga_vsync = r_vsync;
    assign active_mode   = r_active_mode;
endmodule
